// File: rtl/hvsync_rx_pkg.sv
// Shared types and constants for the hsync/vsync video receiver.
package hvsync_rx_pkg;

   localparam int DEF_H_W = 10;
   localparam int DEF_V_W = 10;
   localparam int RGB_W   = 3;
   localparam int SUM_W   = 16;
   localparam int MATCH_W = 4;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

   // Maps a raw sync pin to active-high.
   function automatic logic norm_sync(input logic s, input logic active_low);
      return active_low ? ~s : s;
   endfunction

endpackage

// File: rtl/hvsync_receiver_if.sv
// Pixel stream from a video generator: strobe, syncs and colour.
interface hvsync_receiver_if;
   import hvsync_rx_pkg::*;

   logic             pix_en;
   logic             hsync;
   logic             vsync;
   logic [RGB_W-1:0] rgb;

   modport master (output pix_en, hsync, vsync, rgb);
   modport slave  (input  pix_en, hsync, vsync, rgb);

endinterface

// File: rtl/sync_period_meter.sv
// Period meter: counts inc pulses between evt pulses, latches the period
// on evt and flags an attempted count past all-ones (counter holds there).
module sync_period_meter #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         evt,
   output logic [W-1:0] cnt,
   output logic [W-1:0] total,
   output logic [W-1:0] meas,
   output logic         sat
);

   localparam logic [W-1:0] CNT_MAX = '1;

   // Period that would be latched if evt fired on this cycle.
   assign meas = cnt + W'(1);
   assign sat  = inc && !evt && (cnt == CNT_MAX);

   // Counter restarts at the event; otherwise counts up and sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt   <= '0;
         total <= '0;
      end else if (evt) begin
         total <= meas;
         cnt   <= '0;
      end else if (inc && !sat) begin
         cnt   <= meas;
      end
   end

endmodule

// File: rtl/hvsync_receiver.sv
// Video sink monitor: samples sync/colour per pixel, measures line and frame
// periods, recovers x/y, tracks timing lock and sums rgb per frame.
module hvsync_receiver
   import hvsync_rx_pkg::*;
#(
   parameter int H_W         = DEF_H_W,
   parameter int V_W         = DEF_V_W,
   parameter bit SYNC_LOW    = 1'b1,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              clk,
   input  logic              reset,
   hvsync_receiver_if.slave  vid,
   output logic [H_W-1:0]    x,
   output logic [V_W-1:0]    y,
   output logic              pix_valid,
   output logic [RGB_W-1:0]  rgb_out,
   output logic [H_W-1:0]    h_total,
   output logic [V_W-1:0]    v_total,
   output logic              locked,
   output logic              frame_done,
   output logic [SUM_W-1:0]  frame_sum,
   output logic              err
);

   localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(LOCK_FRAMES);

   // Sampling stage
   logic             s_vld;
   logic             hs_cur, hs_prev;
   logic             vs_cur, vs_prev;
   logic [RGB_W-1:0] rgb_s;
   logic             hs_edge, vs_edge;

   // Meter taps
   logic [H_W-1:0]   h_meas, h_tot_nxt;
   logic [V_W-1:0]   v_meas;
   logic             h_sat, v_sat;

   // Lock FSM
   rx_state_t        state, state_nxt;
   logic [MATCH_W-1:0] match, match_nxt, match_inc;
   logic [H_W-1:0]   ref_h, ref_h_nxt;
   logic [V_W-1:0]   ref_v, ref_v_nxt;

   // Checksum
   logic [SUM_W-1:0] acc;
   logic [SUM_W-1:0] rgb_ext;

   // Capture one pixel per strobe; the previous sample is kept for edge detect.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      if (!reset) begin
         s_vld   <= 1'b0;
         hs_cur  <= 1'b0;
         hs_prev <= 1'b0;
         vs_cur  <= 1'b0;
         vs_prev <= 1'b0;
         rgb_s   <= '0;
      end else begin
         s_vld <= vid.pix_en;
         if (vid.pix_en) begin
            hs_prev <= hs_cur;
            vs_prev <= vs_cur;
            hs_cur  <= norm_sync(vid.hsync, SYNC_LOW);
            vs_cur  <= norm_sync(vid.vsync, SYNC_LOW);
            rgb_s   <= vid.rgb;
         end
      end
   end

   assign hs_edge   = s_vld && hs_cur && !hs_prev;
   assign vs_edge   = s_vld && vs_cur && !vs_prev;
   assign rgb_ext   = SUM_W'(rgb_s);
   assign h_tot_nxt = hs_edge ? h_meas : h_total;
   assign match_inc = match + MATCH_W'(1);

   sync_period_meter #(.W(H_W)) u_h_meter (
      .clk   (clk),
      .reset (reset),
      .inc   (s_vld),
      .evt   (hs_edge),
      .cnt   (x),
      .total (h_total),
      .meas  (h_meas),
      .sat   (h_sat)
   );

   sync_period_meter #(.W(V_W)) u_v_meter (
      .clk   (clk),
      .reset (reset),
      .inc   (hs_edge),
      .evt   (vs_edge),
      .cnt   (y),
      .total (v_total),
      .meas  (v_meas),
      .sat   (v_sat)
   );

   // Lock decision: compare freshly measured periods against the reference.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt = state;
      match_nxt = match;
      ref_h_nxt = ref_h;
      ref_v_nxt = ref_v;
      case (state)
         ST_SEARCH: begin
            if (vs_edge) begin
               state_nxt = ST_MEASURE;
               ref_h_nxt = h_tot_nxt;
               ref_v_nxt = v_meas;
               match_nxt = '0;
            end
         end
         ST_MEASURE: begin
            if (vs_edge) begin
               if (h_tot_nxt == ref_h && v_meas == ref_v) begin
                  match_nxt = match_inc;
                  if (match_inc == LOCK_N) state_nxt = ST_LOCKED;
               end else begin
                  ref_h_nxt = h_tot_nxt;
                  ref_v_nxt = v_meas;
                  match_nxt = '0;
               end
            end
         end
         ST_LOCKED: begin
            if ((hs_edge && h_meas != ref_h) || (vs_edge && v_meas != ref_v)) begin
               state_nxt = ST_SEARCH;
               match_nxt = '0;
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
      if (h_sat || v_sat) begin
         state_nxt = ST_SEARCH;
         match_nxt = '0;
      end
   end

   // Lock state and reference registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_SEARCH;
         match <= '0;
         ref_h <= '0;
         ref_v <= '0;
      end else begin
         state <= state_nxt;
         match <= match_nxt;
         ref_h <= ref_h_nxt;
         ref_v <= ref_v_nxt;
      end
   end

   assign locked = (state == ST_LOCKED);

   // Per-sample outputs, sticky error and per-frame rgb checksum.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         rgb_out    <= '0;
         frame_sum  <= '0;
         acc        <= '0;
         err        <= 1'b0;
      end else begin
         pix_valid  <= s_vld && (state_nxt == ST_LOCKED);
         frame_done <= vs_edge;
         if (h_sat || v_sat) err <= 1'b1;
         if (s_vld) begin
            rgb_out <= rgb_s;
            if (vs_edge) begin
               acc <= '0;
               // A frame started while searching is partial: drop it.
               if (state != ST_SEARCH) frame_sum <= acc + rgb_ext;
            end else begin
               acc <= acc + rgb_ext;
            end
         end
      end
   end

endmodule

// File: tb/tb_hvsync_receiver.sv
// Bench for hvsync_receiver: 16x10 generator (2-pixel/2-line syncs),
// randomized strobe gaps and colours, behavioural model checked every cycle.
module tb_hvsync_receiver;
   import hvsync_rx_pkg::*;

   localparam int H_W         = 10;
   localparam int V_W         = 10;
   localparam bit SYNC_LOW    = 1'b1;
   localparam int LOCK_FRAMES = 2;
   localparam int HMAX        = (1 << H_W) - 1;
   localparam int VMAX        = (1 << V_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   hvsync_receiver_if vif();

   logic [H_W-1:0]   x;
   logic [V_W-1:0]   y;
   logic             pix_valid;
   logic [RGB_W-1:0] rgb_out;
   logic [H_W-1:0]   h_total;
   logic [V_W-1:0]   v_total;
   logic             locked;
   logic             frame_done;
   logic [SUM_W-1:0] frame_sum;
   logic             err;

   hvsync_receiver #(
      .H_W(H_W), .V_W(V_W), .SYNC_LOW(SYNC_LOW), .LOCK_FRAMES(LOCK_FRAMES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .vid        (vif),
      .x          (x),
      .y          (y),
      .pix_valid  (pix_valid),
      .rgb_out    (rgb_out),
      .h_total    (h_total),
      .v_total    (v_total),
      .locked     (locked),
      .frame_done (frame_done),
      .frame_sum  (frame_sum),
      .err        (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   bit gap_rand = 1'b0;
   bit rgb_rand = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pending sample (taken at a strobe edge, visible one clock later).
   bit p_vld, p_hs, p_vs;
   int p_rgb;
   // Model state: samples since line start, lines since frame start, etc.
   bit m_phs, m_pvs;
   int m_hn, m_vn, m_htot, m_vtot, m_acc, m_fsum;
   int m_phase;              // 0 searching, 1 measuring, 2 locked
   int m_refh, m_refv, m_match;
   bit m_err, e_pv, e_fd;
   int e_rgb;

   task automatic mdl_reset();
      p_vld = 0; p_hs = 0; p_vs = 0; p_rgb = 0;
      m_phs = 0; m_pvs = 0;
      m_hn = 0; m_vn = 0; m_htot = 0; m_vtot = 0; m_acc = 0; m_fsum = 0;
      m_phase = 0; m_refh = 0; m_refv = 0; m_match = 0;
      m_err = 0; e_pv = 0; e_fd = 0; e_rgb = 0;
   endtask

   task automatic mdl_sample(input bit hs, input bit vs, input int c);
      bit he, ve, sat;
      he = hs && !m_phs;
      ve = vs && !m_pvs;
      m_phs = hs;
      m_pvs = vs;
      sat = 0;
      if (he) begin
         m_htot = (m_hn + 1) % (HMAX + 1);
         m_hn = 0;
      end else if (m_hn < HMAX) m_hn++;
      else sat = 1;
      if (ve) begin
         m_vtot = (m_vn + 1) % (VMAX + 1);
         m_vn = 0;
      end else if (he) begin
         if (m_vn < VMAX) m_vn++;
         else sat = 1;
      end
      e_fd = ve;
      if (ve) begin
         if (m_phase != 0) m_fsum = (m_acc + c) % 65536;
         m_acc = 0;
      end else m_acc = m_acc + c;
      if (m_phase == 0) begin
         if (ve) begin
            m_phase = 1; m_refh = m_htot; m_refv = m_vtot; m_match = 0;
         end
      end else if (m_phase == 1) begin
         if (ve) begin
            if (m_htot == m_refh && m_vtot == m_refv) begin
               m_match++;
               if (m_match == LOCK_FRAMES) m_phase = 2;
            end else begin
               m_refh = m_htot; m_refv = m_vtot; m_match = 0;
            end
         end
      end else begin
         if ((he && m_htot != m_refh) || (ve && m_vtot != m_refv)) begin
            m_phase = 0; m_match = 0;
         end
      end
      if (sat) begin
         m_err = 1; m_phase = 0; m_match = 0;
      end
      e_pv = (m_phase == 2);
      e_rgb = c;
   endtask

   initial begin
      mdl_reset();
      forever begin
         @(posedge clk);
         if (!reset) mdl_reset();
         else begin
            e_pv = 0;
            e_fd = 0;
            if (p_vld) mdl_sample(p_hs, p_vs, p_rgb);
            p_vld = vif.pix_en;
            if (vif.pix_en) begin
               p_hs  = SYNC_LOW ? !vif.hsync : vif.hsync;
               p_vs  = SYNC_LOW ? !vif.vsync : vif.vsync;
               p_rgb = int'(vif.rgb);
            end
         end
      end
   end

   // Compare every output against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("x",          32'(x),          32'(m_hn));
            check("y",          32'(y),          32'(m_vn));
            check("pix_valid",  32'(pix_valid),  32'(e_pv));
            check("rgb_out",    32'(rgb_out),    32'(e_rgb));
            check("h_total",    32'(h_total),    32'(m_htot));
            check("v_total",    32'(v_total),    32'(m_vtot));
            check("locked",     32'(locked),     32'(m_phase == 2));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("frame_sum",  32'(frame_sum),  32'(m_fsum));
            check("err",        32'(err),        32'(m_err));
            if (frame_done && locked) begin
               check("edge_x", 32'(x), 32'd0);
               check("edge_y", 32'(y), 32'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      vif.pix_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic drive_px(input bit hs_a, input bit vs_a, input logic [2:0] c);
      int gap;
      gap = gap_rand ? int'($urandom_range(1, 3)) : 2;
      vif.pix_en = 1'b1;
      vif.hsync  = SYNC_LOW ? !hs_a : hs_a;
      vif.vsync  = SYNC_LOW ? !vs_a : vs_a;
      vif.rgb    = c;
      tick();
      vif.pix_en = 1'b0;
      for (int i = 1; i < gap; i++) begin
         // Junk between strobes must be ignored.
         vif.hsync = 1'($urandom);
         vif.vsync = 1'($urandom);
         vif.rgb   = 3'($urandom);
         tick();
      end
   endtask

   task automatic send_line(input int gy, input int len);
      for (int gx = 0; gx < len; gx++)
         drive_px(gx < 2, gy < 2, rgb_rand ? 3'($urandom) : 3'(gx));
   endtask

   task automatic send_frame(input int stretch_line);
      for (int gy = 0; gy < 10; gy++)
         send_line(gy, (gy == stretch_line) ? 17 : 16);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_x"},         32'(x),          32'd0);
      check({tag, "_y"},         32'(y),          32'd0);
      check({tag, "_pix_valid"}, 32'(pix_valid),  32'd0);
      check({tag, "_rgb_out"},   32'(rgb_out),    32'd0);
      check({tag, "_h_total"},   32'(h_total),    32'd0);
      check({tag, "_v_total"},   32'(v_total),    32'd0);
      check({tag, "_locked"},    32'(locked),     32'd0);
      check({tag, "_frame_done"},32'(frame_done), 32'd0);
      check({tag, "_frame_sum"}, 32'(frame_sum),  32'd0);
      check({tag, "_err"},       32'(err),        32'd0);
   endtask

   initial begin
      vif.pix_en = 1'b0;
      vif.hsync  = 1'b1;
      vif.vsync  = 1'b1;
      vif.rgb    = '0;
      reset      = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      check_all_zero("reset");
      reset = 1'b1;

      // Clean stream: lock and steady-state measurements.
      repeat (6) send_frame(-1);
      idle(2);
      check("lock_h_total", 32'(h_total),   32'd16);
      check("lock_v_total", 32'(v_total),   32'd10);
      check("lock_locked",  32'(locked),    32'd1);
      check("lock_sum",     32'(frame_sum), 32'h230);
      check("lock_err",     32'(err),       32'd0);
      check("lock_x_end",   32'(x),         32'd15);
      check("lock_y_end",   32'(y),         32'd9);

      // One 17-pixel line drops lock; clean frames re-acquire it.
      send_frame(5);
      idle(2);
      check("stretch_unlocked", 32'(locked), 32'd0);
      repeat (4) send_frame(-1);
      idle(2);
      check("relock_locked", 32'(locked),    32'd1);
      check("relock_sum",    32'(frame_sum), 32'h230);

      // Random colours, random strobe spacing, occasional stretched line.
      rgb_rand = 1'b1;
      gap_rand = 1'b1;
      repeat (3) send_frame(int'($urandom_range(0, 15)));
      rgb_rand = 1'b0;
      gap_rand = 1'b0;
      repeat (3) send_frame(-1);
      idle(2);

      // Missing hsync long enough to saturate the line counter.
      for (int i = 0; i < 1100; i++) drive_px(1'b0, 1'b0, 3'(i));
      idle(2);
      check("sat_err",    32'(err),    32'd1);
      check("sat_locked", 32'(locked), 32'd0);
      check("sat_x",      32'(x),      32'(HMAX));
      repeat (4) send_frame(-1);
      idle(2);
      check("sat_err_sticky", 32'(err), 32'd1);

      // Reset in the middle of a frame, then resume the same stream.
      for (int gy = 0; gy < 5; gy++) send_line(gy, 16);
      reset      = 1'b0;
      vif.pix_en = 1'b0;
      tick();
      check_all_zero("midreset");
      reset = 1'b1;
      for (int gy = 5; gy < 10; gy++) send_line(gy, 16);
      repeat (4) send_frame(-1);
      idle(2);
      check("post_reset_locked",  32'(locked),  32'd1);
      check("post_reset_err",     32'(err),     32'd0);
      check("post_reset_h_total", 32'(h_total), 32'd16);
      check("post_reset_v_total", 32'(v_total), 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
